// File: rtl/mul_pkg.sv
// +-----------------------------------------------------------------+
// | mul_pkg : shared width, count width helper and FSM encoding     |
// | Revision: 1.0                                                   |
// +-----------------------------------------------------------------+
`default_nettype none

package mul_pkg;

  localparam int MUL_WIDTH = 16;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mul_state_e;

  // The counter must be able to hold WIDTH itself, not just WIDTH-1.
  function automatic int mul_cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  localparam int MUL_CNT_W = mul_cnt_width(MUL_WIDTH);

endpackage

`default_nettype wire

// File: rtl/mul_step.sv
// +-----------------------------------------------------------------+
// | mul_step : one combinational shift-add iteration                |
// | Revision: 1.0                                                   |
// +-----------------------------------------------------------------+
`default_nettype none

module mul_step #(
  parameter int WIDTH = 16
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [2*WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0]   mplr,
  output logic [2*WIDTH-1:0] acc_nxt,
  output logic [2*WIDTH-1:0] mcand_nxt,
  output logic [WIDTH-1:0]   mplr_nxt
);

  always_comb begin
    acc_nxt   = mplr[0] ? (acc + mcand) : acc;
    mcand_nxt = {mcand[2*WIDTH-2:0], 1'b0};
    mplr_nxt  = {1'b0, mplr[WIDTH-1:1]};
  end

endmodule

`default_nettype wire

// File: rtl/multiplier_seq.sv
// +-----------------------------------------------------------------+
// | multiplier_seq : shift-add multiplier, product = A*B + addend   |
// | Option macro MUL_EARLY_TERM_EN: finish once multiplier drains.  |
// | Revision: 1.0                                                   |
// +-----------------------------------------------------------------+
`default_nettype none

module multiplier_seq
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic [WIDTH-1:0]   addend,
  output logic [2*WIDTH-1:0] product,
  output logic               ready,
  output logic               done
);

  localparam int CNT_W = mul_cnt_width(WIDTH);

  mul_state_e         state_q,   state_d;
  logic [2*WIDTH-1:0] acc_q,     acc_d;
  logic [2*WIDTH-1:0] mcand_q,   mcand_d;
  logic [WIDTH-1:0]   mplr_q,    mplr_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic               ready_q,   ready_d;
  logic               done_q,    done_d;

  logic [2*WIDTH-1:0] step_acc;
  logic [2*WIDTH-1:0] step_mcand;
  logic [WIDTH-1:0]   step_mplr;
  logic               finish;

  mul_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .acc       (acc_q),
    .mcand     (mcand_q),
    .mplr      (mplr_q),
    .acc_nxt   (step_acc),
    .mcand_nxt (step_mcand),
    .mplr_nxt  (step_mplr)
  );

`ifdef MUL_EARLY_TERM_EN
  // Once no multiplier bits remain, further iterations cannot change acc.
  assign finish = (cnt_q == CNT_W'(1)) || (step_mplr == '0);
`else
  assign finish = (cnt_q == CNT_W'(1));
`endif

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplr_d    = mplr_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    ready_d   = ready_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d   = {{WIDTH{1'b0}}, addend};
          mcand_d = {{WIDTH{1'b0}}, multiplicand};
          mplr_d  = multiplier;
          cnt_d   = CNT_W'(WIDTH);
          ready_d = 1'b0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_d   = step_acc;
        mcand_d = step_mcand;
        mplr_d  = step_mplr;
        cnt_d   = cnt_q - CNT_W'(1);
        if (finish) begin
          product_d = step_acc;
          done_d    = 1'b1;
          ready_d   = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplr_q    <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplr_q    <= mplr_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
    end
  end

  assign product = product_q;
  assign ready   = ready_q;
  assign done    = done_q;

endmodule

`default_nettype wire
